// File: rtl/hi_lo_unit.sv
// HI/LO register pair with MTHI/MTLO/MULT writeback and an iterative
// 32-step restoring divider for DIV/DIVU. Stalls HI/LO ops while dividing.
module hi_lo_unit #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [5:0]  ALU_operation,
    input  logic [31:0] input_1,
    input  logic [31:0] input_2,
    input  logic [31:0] ALU_HI_output,
    input  logic [31:0] ALU_LO_output,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        div_done
);

    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [31:0] divisor;     // divisor magnitude
    logic [31:0] dvd;         // dividend magnitude, shifts out as quotient shifts in
    logic [32:0] rem;         // partial remainder
    logic        q_neg;
    logic        r_neg;
    logic        dbz;
    logic [31:0] orig_a;      // raw input_1 for the divide-by-zero remainder
    logic [31:0] hi_r, lo_r;

    logic        is_hilo;
    logic        is_div;
    logic        is_signed;
    logic        accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] q_fix, r_fix;

    // Decode the HI/LO op class and the accept/stall handshake.
    always_comb begin
        is_hilo = 1'b0;
        case (ALU_operation)
            OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_hilo = 1'b1;
            default:                            is_hilo = 1'b0;
        endcase
        is_div    = (ALU_operation == OP_DIV) || (ALU_operation == OP_DIVU);
        is_signed = (ALU_operation == OP_DIV);
        busy      = (state != IDLE);
        stall     = op_valid & busy & is_hilo;
        accept    = op_valid & ~stall;
        div_done  = (state == FIX);
    end

    // Operand magnitudes for the divider; unsigned ops pass through raw.
    always_comb begin
        a_mag = (is_signed && input_1[31]) ? (~input_1 + 32'd1) : input_1;
        b_mag = (is_signed && input_2[31]) ? (~input_2 + 32'd1) : input_2;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // The partial remainder stays below the divisor, so 33 bits hold the
    // shifted value and the sign of the trial difference.
    always_comb begin
        shifted = {rem[31:0], dvd[31]};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[32];
    end

    // Final sign correction: quotient truncates toward zero, remainder
    // follows the dividend's sign. Divide by zero bypasses the magnitudes.
    always_comb begin
        q_fix = q_neg ? (~dvd + 32'd1) : dvd;
        r_fix = r_neg ? (~rem[31:0] + 32'd1) : rem[31:0];
        if (dbz) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = orig_a;
        end
    end

    // Divider sequencing: IDLE -> RUN for 32 steps -> FIX -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_div) state_next = RUN;
            RUN:     if (count == LAST_STEP) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset mid-division aborts without writing results.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Divider datapath: capture operands at start, iterate during RUN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count   <= '0;
            divisor <= '0;
            dvd     <= '0;
            rem     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dbz     <= 1'b0;
            orig_a  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_div) begin
                        divisor <= b_mag;
                        dvd     <= a_mag;
                        rem     <= '0;
                        count   <= '0;
                        q_neg   <= is_signed & (input_1[31] ^ input_2[31]);
                        r_neg   <= is_signed & input_1[31];
                        dbz     <= (input_2 == 32'd0);
                        orig_a  <= input_1;
                    end
                end
                RUN: begin
                    rem   <= q_bit ? trial : shifted;
                    dvd   <= {dvd[30:0], q_bit};
                    count <= count + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Architectural HI/LO: moves, multiply results, divide results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state == FIX) begin
            lo_r <= q_fix;
            hi_r <= r_fix;
        end else if (accept) begin
            case (ALU_operation)
                OP_MTHI: hi_r <= input_1;
                OP_MTLO: lo_r <= input_1;
                OP_MULT, OP_MULTU: begin
                    hi_r <= ALU_HI_output;
                    lo_r <= ALU_LO_output;
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Directed bench for hi_lo_unit: moves, multiply writeback, divider results,
// busy/stall timing, reset abort and non-HI/LO ops during a division.
module tb_hi_lo_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic [5:0]  ALU_operation;
    logic [31:0] input_1, input_2;
    logic [31:0] ALU_HI_output, ALU_LO_output;
    logic [31:0] hi, lo;
    logic        busy, stall, div_done;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001;
    localparam logic [5:0] MFLO = 6'b010010, MTLO = 6'b010011;
    localparam logic [5:0] MULT = 6'b011000;
    localparam logic [5:0] DIV  = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] ADDU = 6'b100001;

    hi_lo_unit dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid),
        .ALU_operation(ALU_operation), .input_1(input_1), .input_2(input_2),
        .ALU_HI_output(ALU_HI_output), .ALU_LO_output(ALU_LO_output),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .div_done(div_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        op_valid      = 1'b1;
        ALU_operation = op;
        input_1       = a;
        input_2       = b;
        #1;
    endtask

    // Start a divide, let it run to completion, check the result.
    task automatic run_div(input string tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        issue(op, a, b);
        tick();
        op_valid = 1'b0;
        repeat (33) tick();
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int busy_cnt, stall_cnt, done_at, done_cnt;

        reset_n = 1'b0; op_valid = 1'b0; ALU_operation = '0;
        input_1 = '0; input_2 = '0; ALU_HI_output = '0; ALU_LO_output = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, div_done}, 32'd0);

        // Moves
        issue(MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_stall", {31'd0, stall}, 32'd0);
        tick();
        issue(MTLO, 32'hDEAD_BEEF, 32'd0);
        tick();
        issue(MFHI, 32'h0, 32'd0);
        chk("mfhi_stall", {31'd0, stall}, 32'd0);
        chk("mfhi_hi", hi, 32'h1234_5678);
        tick();
        chk("mtlo_lo", lo, 32'hDEAD_BEEF);
        chk("mf_hi_keep", hi, 32'h1234_5678);

        // Multiply writeback
        ALU_HI_output = 32'hFFFF_FFFF;
        ALU_LO_output = 32'hFFFF_FFFA;
        issue(MULT, 32'd0, 32'd0);
        tick();
        op_valid = 1'b0;
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_busy", {31'd0, busy}, 32'd0);

        // DIVU 100/7 with a held MFLO and operands changing mid-run
        issue(DIVU, 32'd100, 32'd7);
        tick();                                  // E0
        issue(MFLO, 32'hAAAA_5555, 32'd3);
        busy_cnt = 0; stall_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 33; i++) begin
            if (busy) busy_cnt++;
            if (stall) stall_cnt++;
            if (div_done) begin done_cnt++; done_at = i; end
            if (i == 20) chk("divu_mid_lo", lo, 32'hFFFF_FFFA);
            tick();
        end                                      // now after E33
        chk("divu_busy_cycles", busy_cnt, 33);
        chk("divu_stall_cycles", stall_cnt, 33);
        chk("divu_done_count", done_cnt, 1);
        chk("divu_done_at", done_at, 32);
        chk("divu_busy_after", {31'd0, busy}, 32'd0);
        chk("divu_stall_after", {31'd0, stall}, 32'd0);
        chk("divu_done_after", {31'd0, div_done}, 32'd0);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        tick();                                  // E34 accepts MFLO
        op_valid = 1'b0;
        chk("mflo_keep_lo", lo, 32'd14);

        // Signed and boundary divides
        run_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_div("div_m5_by0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_div("divu_big", DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);

        // ADDU during RUN: no stall, no effect on the division
        issue(DIV, 32'd100, 32'hFFFF_FFF9);
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        issue(ADDU, 32'h1111_1111, 32'h2222_2222);
        chk("addu_stall", {31'd0, stall}, 32'd0);
        chk("addu_busy", {31'd0, busy}, 32'd1);
        tick();
        op_valid = 1'b0;
        repeat (27) tick();
        chk("div_neg_lo", lo, 32'hFFFF_FFF2);
        chk("div_neg_hi", hi, 32'd2);

        // Reset after ten steps aborts the division
        issue(DIVU, 32'd100, 32'd7);
        tick();
        op_valid = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_done) done_cnt++;
            tick();
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_lo_later", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
- Holds the architectural HI/LO register pair downstream of the ALU and consumes its 64-bit HI/LO result for MULT/MULTU.
- Executes DIV/DIVU itself with an iterative 32-step restoring divider, replacing the single-cycle combinational divide path.
- Provides a busy/stall handshake so the pipeline holds any HI/LO-touching instruction until a division completes.
- Sits beside the ALU in execute; its hi/lo outputs feed the MFHI/MFLO writeback mux.

Parameters:
- DIV_STEPS, 32, quotient bits produced (one per cycle); fixed at the data width, not user-tunable beyond 32.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- op_valid  input  1  ALU_operation/operands are valid this cycle
- ALU_operation  input  6  same function encoding the ALU decodes
- input_1  input  32  rs operand (dividend / MTHI/MTLO source)
- input_2  input  32  rt operand (divisor)
- ALU_HI_output  input  32  ALU product upper word (MULT/MULTU)
- ALU_LO_output  input  32  ALU product lower word (MULT/MULTU)
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  divider running
- stall  output  1  hold current instruction; do not advance
- div_done  output  1  one-cycle pulse on the cycle hi/lo take a divide result

Behaviour:
- Reset (reset_n=0 at posedge): hi=0, lo=0, busy=0, div_done=0, state=IDLE, iteration count=0.
  - Reset mid-division aborts it; no partial result is written.
- HI/LO op class: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - All other codes are ignored and never stall.
- stall = op_valid & busy & (op in HI/LO class); purely combinational.
  - A stalled op has no effect.
  - The pipeline re-presents it until stall drops.
- An op is accepted at a posedge when op_valid=1 and stall=0.
- Accepted actions:
  - MTHI: hi<=input_1. MTLO: lo<=input_1. Both take effect at that edge; the other register is unchanged.
  - MULT/MULTU: hi<=ALU_HI_output, lo<=ALU_LO_output at that edge (1-cycle latency).
  - MFHI/MFLO: no state change; the pipeline reads the hi/lo outputs directly. They are valid whenever stall=0.
  - DIV/DIVU: start the divider, IDLE->RUN.
- State machine: IDLE, RUN, FIX.
- IDLE, on accepted DIV/DIVU at edge E0:
  - Latch divisor magnitude and dividend magnitude. Signed op: |x| via two's complement; unsigned: raw.
  - Latch quotient sign = sign1 XOR sign2 and remainder sign = sign1 (DIV only).
  - Latch a divide-by-zero flag and original input_1; clear the 33-bit partial remainder; count=0.
- RUN: each edge performs one restoring step.
  - Shift {rem, dividend} left 1; trial subtract the divisor.
  - If the result is non-negative, keep it and set quotient bit 1; else restore and set quotient bit 0.
  - count++. After the 32nd step (edge E32) go to FIX.
- FIX (edge E33):
  - Apply sign correction: negate quotient if quotient sign set; negate remainder if remainder sign set.
  - Write lo<=quotient, hi<=remainder; div_done=1 for this one cycle; go to IDLE.
- busy=1 for the 33 cycles after E0 (state!=IDLE); busy=0 in the cycle after E33.
  - Earliest next HI/LO op is accepted at edge E34.
- Divide by zero, either signedness: lo=32'hFFFF_FFFF, hi=input_1 as captured at E0. Timing is identical (33 busy cycles).
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. This falls out of the magnitude algorithm and must not trap.
- Signed results truncate toward zero; the remainder takes the dividend's sign. Example: -7/2 gives lo=-3, hi=-1.
- Operands are captured at E0; later changes on input_1/input_2 during RUN have no effect.
- An op accepted at the same edge busy falls is not possible: stall covers the whole FIX cycle.

Test Plan:
- Reset, then MTHI 32'h1234_5678, MTLO 32'hDEAD_BEEF, MFHI -> hi=32'h1234_5678, lo=32'hDEAD_BEEF, stall never asserted.
- MULT with ALU_HI_output=32'hFFFF_FFFF, ALU_LO_output=32'hFFFF_FFFA -> next edge hi/lo equal those values; busy stays 0.
- DIVU 100/7 -> busy high exactly 33 cycles, div_done pulses at E33, lo=14, hi=2.
  - MFLO held with stall=1 throughout, accepted at E34.
- DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIV 32'h8000_0000/-1 -> lo=32'h8000_0000, hi=0.
- DIVU 5/0 -> lo=32'hFFFF_FFFF, hi=5.
- Reset at count=10 mid-DIV -> hi=lo=0, busy=0 next cycle, no div_done.
- ADDU presented during RUN -> stall=0; the division result is unaffected.
